mac_pipe_sequencer: RTL and testbench

//  Sequences a dot-product job through the 2-lane multiply-add pipeline.
//  - Pipeline: C = A1*B1 + A2*B2, registered inputs, 3-cycle latency, no enable, no reset.
//  - Per job: accepts `len` operand beats over a valid/ready source, drives them into the pipeline, tracks in-flight beats, accumulates every retired C, then pulses done.

---
 rtl/mac_seq_pkg.sv | 13 +
 rtl/mac_seq_mul_add_pipe.sv | 32 +++
 rtl/mac_seq_valid_shreg.sv | 25 ++
 rtl/mac_pipe_sequencer.sv | 148 ++++++++++++++
 tb/tb_mac_pipe_sequencer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_seq_pkg.sv
// Shared types and defaults for the MAC pipeline sequencer.
package mac_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int PIPE_LAT_DEFAULT = 3;

endpackage

// File: rtl/mac_seq_mul_add_pipe.sv
// Two-lane multiply-add pipeline: C = A1*B1 + A2*B2, three register stages, no reset.
module mac_seq_mul_add_pipe #(
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic [DATA_W-1:0] A1,
    input  logic [DATA_W-1:0] A2,
    input  logic [DATA_W-1:0] B1,
    input  logic [DATA_W-1:0] B2,
    output logic [DATA_W-1:0] C
);

    logic [DATA_W-1:0] a1_p0, a2_p0, b1_p0, b2_p0;
    logic [DATA_W-1:0] prod1_p1, prod2_p1;
    logic [DATA_W-1:0] sum_p2;

    always_ff @(posedge Clk) begin
        // p0: operand capture
        a1_p0    <= A1;
        a2_p0    <= A2;
        b1_p0    <= B1;
        b2_p0    <= B2;
        // p1: lane products
        prod1_p1 <= a1_p0 * b1_p0;
        prod2_p1 <= a2_p0 * b2_p0;
        // p2: lane sum
        sum_p2   <= prod1_p1 + prod2_p1;
    end

    assign C = sum_p2;

endmodule

// File: rtl/mac_seq_valid_shreg.sv
// In-flight valid bits for beats travelling through the multiply-add pipeline.
module mac_seq_valid_shreg
    import mac_seq_pkg::*;
#(
    parameter int DEPTH = PIPE_LAT_DEFAULT
) (
    input  logic Clk,
    input  logic Rst,
    input  logic in,
    output logic out
);

    logic [DEPTH-1:0] vld_p;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            vld_p <= '0;
        end else begin
            vld_p <= (vld_p << 1) | DEPTH'(in);
        end
    end

    assign out = vld_p[DEPTH-1];

endmodule

// File: rtl/mac_pipe_sequencer.sv
// Feeds a dot-product job through the multiply-add pipeline and accumulates the results.
// Optional sticky carry-out flag enabled with `define MAC_SEQ_OVF_EN.
module mac_pipe_sequencer
    import mac_seq_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = PIPE_LAT_DEFAULT
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              ovf,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic [DATA_W-1:0] src_A1,
    input  logic [DATA_W-1:0] src_A2,
    input  logic [DATA_W-1:0] src_B1,
    input  logic [DATA_W-1:0] src_B2,
    output logic [DATA_W-1:0] pipe_A1,
    output logic [DATA_W-1:0] pipe_A2,
    output logic [DATA_W-1:0] pipe_B1,
    output logic [DATA_W-1:0] pipe_B2,
    input  logic [DATA_W-1:0] pipe_C
);

    state_t            state;
    logic              busy_q;
    logic              done_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued;
    logic [LEN_W-1:0]  retired;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] acc_sum;
    logic              hs;
    logic              retire;

    assign src_ready = (state == ISSUE) && (issued < len_q);
    assign hs        = src_valid && src_ready;

    // Idle slots carry zeros so the pipeline never sees stale source data.
    assign pipe_A1 = hs ? src_A1 : '0;
    assign pipe_A2 = hs ? src_A2 : '0;
    assign pipe_B1 = hs ? src_B1 : '0;
    assign pipe_B2 = hs ? src_B2 : '0;

    mac_seq_valid_shreg #(
        .DEPTH (PIPE_LAT)
    ) u_vld (
        .Clk (Clk),
        .Rst (Rst),
        .in  (hs),
        .out (retire)
    );

`ifdef MAC_SEQ_OVF_EN
    function automatic logic [DATA_W:0] acc_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    logic acc_carry;
    logic ovf_q;

    assign {acc_carry, acc_sum} = acc_add(result_q, pipe_C);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ovf_q <= 1'b0;
        end else if ((state == IDLE) && start) begin
            ovf_q <= 1'b0;
        end else if (retire) begin
            ovf_q <= ovf_q | acc_carry;
        end
    end

    assign ovf = ovf_q;
`else
    assign acc_sum = result_q + pipe_C;
    assign ovf     = 1'b0;
`endif

    // Issue and retire counters advance independently; the FSM only watches them.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            len_q    <= '0;
            issued   <= '0;
            retired  <= '0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (hs) begin
                issued <= issued + LEN_W'(1);
            end
            if (retire) begin
                retired  <= retired + LEN_W'(1);
                result_q <= acc_sum;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        len_q    <= len;
                        issued   <= '0;
                        retired  <= '0;
                        result_q <= '0;
                        busy_q   <= 1'b1;
                        if (len == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (hs && (issued == len_q - LEN_W'(1))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (retire && (retired == len_q - LEN_W'(1))) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mac_pipe_sequencer.sv
// Table-driven bench for mac_pipe_sequencer with the real multiply-add pipeline attached.
module tb_mac_pipe_sequencer;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 8;
`ifdef MAC_SEQ_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    typedef logic [4*DATA_W-1:0] cv_t;

    typedef struct {
        int                         len;
        bit                         gaps;
        bit                         poke;
        logic [3:0][DATA_W-1:0]     a1;
        logic [3:0][DATA_W-1:0]     b1;
        logic [3:0][DATA_W-1:0]     a2;
        logic [3:0][DATA_W-1:0]     b2;
        logic [DATA_W-1:0]          exp_res;
        bit                         exp_ovf;
    } vec_t;

    typedef struct {
        logic [DATA_W-1:0] res;
        bit                ovf;
    } exp_t;

    logic              Clk = 1'b0;
    logic              Rst;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              busy, done, ovf;
    logic [DATA_W-1:0] result;
    logic              src_valid, src_ready;
    logic [DATA_W-1:0] src_A1, src_A2, src_B1, src_B2;
    logic [DATA_W-1:0] pipe_A1, pipe_A2, pipe_B1, pipe_B2, pipe_C;

    vec_t tbl [8];
    exp_t sb_q [$];
    exp_t mon_e;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int done_cnt = 0, done_cyc = 0, hs_cnt = 0, last_hs_edge = 0;
    bit mon_en = 1'b0;

    mac_pipe_sequencer #(.DATA_W(DATA_W), .LEN_W(LEN_W), .PIPE_LAT(3)) dut (
        .Clk(Clk), .Rst(Rst), .start(start), .len(len),
        .busy(busy), .done(done), .result(result), .ovf(ovf),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_A1(src_A1), .src_A2(src_A2), .src_B1(src_B1), .src_B2(src_B2),
        .pipe_A1(pipe_A1), .pipe_A2(pipe_A2), .pipe_B1(pipe_B1), .pipe_B2(pipe_B2),
        .pipe_C(pipe_C)
    );

    mac_seq_mul_add_pipe #(.DATA_W(DATA_W)) u_pipe (
        .Clk(Clk), .A1(pipe_A1), .A2(pipe_A2), .B1(pipe_B1), .B2(pipe_B2), .C(pipe_C)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input cv_t act, input cv_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Monitor: handshake/bubble data on the pipe port, and scoreboard pop on done.
    always @(negedge Clk) begin
        if (mon_en) begin
            if (src_valid && src_ready) begin
                hs_cnt++;
                last_hs_edge = cyc + 1;
                chk("pipe_pass", {pipe_A1, pipe_A2, pipe_B1, pipe_B2},
                    {src_A1, src_A2, src_B1, src_B2});
            end else begin
                chk("pipe_zero", {pipe_A1, pipe_A2, pipe_B1, pipe_B2}, '0);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_at_done", cv_t'(busy), cv_t'(1));
                chk("done_expected", cv_t'(sb_q.size() != 0), cv_t'(1));
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    chk("result", cv_t'(result), cv_t'(mon_e.res));
                    chk("ovf", cv_t'(ovf), cv_t'(mon_e.ovf));
                end
            end
        end
    end

    task automatic init_vec(input int i, input int l, input bit g, input bit p,
                            input logic [DATA_W-1:0] r, input bit o);
        tbl[i].len = l; tbl[i].gaps = g; tbl[i].poke = p;
        tbl[i].exp_res = r; tbl[i].exp_ovf = o;
        tbl[i].a1 = '0; tbl[i].b1 = '0; tbl[i].a2 = '0; tbl[i].b2 = '0;
    endtask

    task automatic set_beat(input int i, input int j, input logic [DATA_W-1:0] a1,
                            input logic [DATA_W-1:0] b1, input logic [DATA_W-1:0] a2,
                            input logic [DATA_W-1:0] b2);
        tbl[i].a1[j] = a1; tbl[i].b1[j] = b1; tbl[i].a2[j] = a2; tbl[i].b2[j] = b2;
    endtask

    task automatic drive_random();
        src_A1 = $urandom; src_A2 = $urandom; src_B1 = $urandom; src_B2 = $urandom;
    endtask

    task automatic run_job(input vec_t v);
        int idx, g, d0, h0, se;
        bit ph, acc;
        exp_t e;
        e.res = v.exp_res;
        e.ovf = v.exp_ovf;
        sb_q.push_back(e);
        d0 = done_cnt;
        h0 = hs_cnt;
        start = 1'b1;
        len = LEN_W'(v.len);
        se = cyc + 1;
        tick();
        start = 1'b0;
        len = LEN_W'($urandom);
        chk("busy_after_start", cv_t'(busy), cv_t'(1));
        chk("ovf_clear_on_start", cv_t'(ovf), cv_t'(0));
        chk("result_clear_on_start", cv_t'(result), cv_t'(0));
        if (v.len == 0) begin
            src_valid = 1'b1;
            drive_random();
            chk("ready_len0", cv_t'(src_ready), cv_t'(0));
            tick();
            chk("ready_len0_idle", cv_t'(src_ready), cv_t'(0));
            src_valid = 1'b0;
        end else begin
            idx = 0; g = 0; ph = 1'b0;
            while (idx < v.len && g < 200) begin
                src_valid = !v.gaps || ph;
                ph = !ph;
                if (src_valid) begin
                    src_A1 = v.a1[idx]; src_B1 = v.b1[idx];
                    src_A2 = v.a2[idx]; src_B2 = v.b2[idx];
                end else begin
                    drive_random();
                end
                if (v.poke && g == 1) begin
                    start = 1'b1;
                    len = LEN_W'(5);
                end else begin
                    start = 1'b0;
                end
                acc = src_valid && src_ready;
                tick();
                g++;
                if (acc) begin
                    idx++;
                    if (idx == v.len) chk("ready_drop", cv_t'(src_ready), cv_t'(0));
                end
            end
            start = 1'b0;
            src_valid = 1'b0;
            drive_random();
            chk("beats_issued", cv_t'(idx), cv_t'(v.len));
        end
        g = 0;
        while (done_cnt == d0 && g < 50) begin
            tick();
            g++;
        end
        chk("done_seen", cv_t'(done_cnt - d0), cv_t'(1));
        if (v.len == 0) chk("done_latency", cv_t'(done_cyc - se), cv_t'(0));
        else            chk("done_latency", cv_t'(done_cyc - last_hs_edge), cv_t'(3));
        chk("hs_count", cv_t'(hs_cnt - h0), cv_t'(v.len));
        chk("busy_after_done", cv_t'(busy), cv_t'(0));
        chk("done_width", cv_t'(done), cv_t'(0));
        tick();
        chk("result_hold", cv_t'(result), cv_t'(v.exp_res));
        chk("ovf_hold", cv_t'(ovf), cv_t'(v.exp_ovf));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, g;
        bit acc;

        init_vec(0, 1, 0, 0, 32'd26, 1'b0);
        set_beat(0, 0, 2, 3, 4, 5);
        init_vec(1, 4, 0, 0, 32'd60, 1'b0);
        init_vec(2, 4, 1, 0, 32'd60, 1'b0);
        for (int j = 0; j < 4; j++) begin
            set_beat(1, j, j + 1, j + 1, j + 1, j + 1);
            set_beat(2, j, j + 1, j + 1, j + 1, j + 1);
        end
        init_vec(3, 0, 0, 0, 32'd0, 1'b0);
        init_vec(4, 2, 0, 0, 32'd0, 1'b0);
        set_beat(4, 0, 32'h1_0000, 32'h1_0000, 0, 0);
        set_beat(4, 1, 32'h1_0000, 32'h1_0000, 0, 0);
        init_vec(5, 2, 0, 0, 32'd0, OVF_ON);
        set_beat(5, 0, 32'h1_0000, 32'h8000, 0, 0);
        set_beat(5, 1, 32'h1_0000, 32'h8000, 0, 0);
        init_vec(6, 3, 0, 0, 32'd1402, 1'b0);
        set_beat(6, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1);
        set_beat(6, 1, 10, 20, 30, 40);
        set_beat(6, 2, 7, 0, 0, 9);
        init_vec(7, 3, 0, 1, 32'd322, 1'b0);
        set_beat(7, 0, 1, 2, 3, 4);
        set_beat(7, 1, 5, 6, 7, 8);
        set_beat(7, 2, 9, 10, 11, 12);

        Rst = 1'b1; start = 1'b0; len = '0; src_valid = 1'b0;
        src_A1 = '0; src_A2 = '0; src_B1 = '0; src_B2 = '0;
        repeat (3) tick();
        chk("rst_busy", cv_t'(busy), cv_t'(0));
        chk("rst_done", cv_t'(done), cv_t'(0));
        chk("rst_ready", cv_t'(src_ready), cv_t'(0));
        chk("rst_ovf", cv_t'(ovf), cv_t'(0));
        chk("rst_result", cv_t'(result), cv_t'(0));
        Rst = 1'b0;
        mon_en = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_job(tbl[i]);
            tick();
        end
        repeat (10) tick();
        chk("done_count", cv_t'(done_cnt), cv_t'(8));

        // Reset in the middle of a len=4 job after two beats are in flight.
        start = 1'b1;
        len = LEN_W'(4);
        tick();
        start = 1'b0;
        n = 0; g = 0;
        while (n < 2 && g < 20) begin
            src_valid = 1'b1;
            drive_random();
            acc = src_valid && src_ready;
            tick();
            g++;
            if (acc) n++;
        end
        src_valid = 1'b0;
        tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk("midrst_busy", cv_t'(busy), cv_t'(0));
        chk("midrst_result", cv_t'(result), cv_t'(0));
        chk("midrst_ready", cv_t'(src_ready), cv_t'(0));
        chk("midrst_done", cv_t'(done), cv_t'(0));
        chk("midrst_ovf", cv_t'(ovf), cv_t'(0));
        repeat (5) tick();
        chk("no_stale_acc", cv_t'(result), cv_t'(0));
        chk("no_stale_done", cv_t'(done_cnt), cv_t'(8));
        run_job(tbl[0]);
        repeat (4) tick();
        chk("scoreboard_empty", cv_t'(sb_q.size()), cv_t'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
